dmi_req_sched: RTL and testbench

Core-clock sequencer between the JTAG TAP and the debug module. It accepts one DMI read or write request at a time from the TAP side and drives it to the debug module through a valid/ready request channel. It then waits for the response, returns read data, and keeps the sticky 2-bit DMI status that the TAP reports back to the debugger. TAP signals arrive already synchronized into the core clock domain.

---
 rtl/dmi_req_sched_if.sv | 38 +++
 rtl/dmi_req_sched.sv | 147 ++++++++++++++
 tb/tb_dmi_req_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_req_sched_if.sv
// DMI request scheduler bus bundle: TAP-side request/status signals and the
// valid/ready request channel plus response strobe toward the debug module.
// The slave modport is the scheduler's view; master is its environment.
interface dmi_req_sched_if;
  logic        io_wr_en;
  logic        io_rd_en;
  logic [6:0]  io_wr_addr;
  logic [31:0] io_wr_data;
  logic        io_dmi_reset;
  logic        io_dmi_hard_reset;
  logic        io_dm_req_valid;
  logic        io_dm_req_ready;
  logic        io_dm_req_write;
  logic [6:0]  io_dm_req_addr;
  logic [31:0] io_dm_req_wdata;
  logic        io_dm_resp_valid;
  logic [31:0] io_dm_resp_data;
  logic        io_dm_resp_err;
  logic [31:0] io_rd_data;
  logic [1:0]  io_dmi_stat;
  logic        io_busy;

  modport slave (
    input  io_wr_en, io_rd_en, io_wr_addr, io_wr_data,
    input  io_dmi_reset, io_dmi_hard_reset,
    input  io_dm_req_ready, io_dm_resp_valid, io_dm_resp_data, io_dm_resp_err,
    output io_dm_req_valid, io_dm_req_write, io_dm_req_addr, io_dm_req_wdata,
    output io_rd_data, io_dmi_stat, io_busy
  );

  modport master (
    output io_wr_en, io_rd_en, io_wr_addr, io_wr_data,
    output io_dmi_reset, io_dmi_hard_reset,
    output io_dm_req_ready, io_dm_resp_valid, io_dm_resp_data, io_dm_resp_err,
    input  io_dm_req_valid, io_dm_req_write, io_dm_req_addr, io_dm_req_wdata,
    input  io_rd_data, io_dmi_stat, io_busy
  );
endinterface

// File: rtl/dmi_req_sched.sv
// dmi_req_sched: sequences one DMI read/write at a time from the TAP side to
// the debug module, waits for the response, returns read data and keeps the
// sticky 2-bit DMI status (0 ok, 2 failed, 3 busy). All outputs are flops.
module dmi_req_sched #(
  parameter int TIMEOUT = 255
) (
  input logic            clock,
  input logic            reset,
  dmi_req_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] STAT_OK   = 2'd0;
  localparam logic [1:0] STAT_FAIL = 2'd2;
  localparam logic [1:0] STAT_BUSY = 2'd3;

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  // Counter is 0 in the first cycle after acceptance, so the abort decision
  // is taken in the cycle that is TIMEOUT cycles after acceptance.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       stat_r, stat_nxt_s;
  logic             valid_r, busy_r, write_r;
  logic [6:0]       addr_r;
  logic [31:0]      wdata_r, rd_data_r;
  logic             req_s, latch_s, rd_upd_s;

  assign req_s = bus.io_wr_en | bus.io_rd_en;

  // Next-state, counter and sticky-status decision for the transaction FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stat_nxt_s  = stat_r;
    latch_s     = 1'b0;
    rd_upd_s    = 1'b0;
    if (bus.io_dmi_hard_reset) begin
      // Abort wins over everything, including a same-cycle request.
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
      stat_nxt_s  = STAT_OK;
    end else begin
      case (state_r)
        IDLE: begin
          // A pending sticky status blocks new requests unless it is
          // being cleared in this very cycle.
          if (req_s && ((stat_r == STAT_OK) || bus.io_dmi_reset)) begin
            latch_s     = 1'b1;
            state_nxt_s = REQ;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        REQ: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            stat_nxt_s  = STAT_FAIL;
          end else if (bus.io_dm_req_ready) begin
            state_nxt_s = RESP;
            cnt_nxt_s   = cnt_r + 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + 1'b1;
          end
        end
        RESP: begin
          // A response in the timeout cycle still counts as on time.
          if (bus.io_dm_resp_valid) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            if (bus.io_dm_resp_err) begin
              stat_nxt_s = STAT_FAIL;
            end else begin
              rd_upd_s = ~write_r;
            end
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            stat_nxt_s  = STAT_FAIL;
          end else begin
            cnt_nxt_s   = cnt_r + 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
      // Overlapping request: flag busy only if no failure is recorded.
      if ((state_r != IDLE) && req_s && (stat_nxt_s == STAT_OK)) begin
        stat_nxt_s = STAT_BUSY;
      end else begin
        stat_nxt_s = stat_nxt_s;
      end
      // Status clear beats any status-setting event in the same cycle.
      if (bus.io_dmi_reset) begin
        stat_nxt_s = STAT_OK;
      end else begin
        stat_nxt_s = stat_nxt_s;
      end
    end
  end

  // State, counter, status and registered output updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      stat_r    <= STAT_OK;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      write_r   <= 1'b0;
      addr_r    <= 7'd0;
      wdata_r   <= 32'd0;
      rd_data_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      stat_r  <= stat_nxt_s;
      valid_r <= (state_nxt_s == REQ);
      busy_r  <= (state_nxt_s != IDLE);
      if (latch_s) begin
        write_r <= bus.io_wr_en;
        addr_r  <= bus.io_wr_addr;
        wdata_r <= bus.io_wr_data;
      end
      if (rd_upd_s) begin
        rd_data_r <= bus.io_dm_resp_data;
      end
    end
  end

  assign bus.io_dm_req_valid = valid_r;
  assign bus.io_dm_req_write = write_r;
  assign bus.io_dm_req_addr  = addr_r;
  assign bus.io_dm_req_wdata = wdata_r;
  assign bus.io_rd_data      = rd_data_r;
  assign bus.io_dmi_stat     = stat_r;
  assign bus.io_busy         = busy_r;

endmodule

// File: tb/tb_dmi_req_sched.sv
// Self-checking bench for dmi_req_sched: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level
// reference model (in-flight flag, handshake-seen flag, age since acceptance).
module tb_dmi_req_sched;
  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dmi_req_sched_if bus ();

  dmi_req_sched #(.TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit          m_busy, m_granted, m_write;
  int          m_age;
  logic [1:0]  m_stat;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_rd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.io_wr_en = 1'b0; bus.io_rd_en = 1'b0;
    bus.io_dmi_reset = 1'b0; bus.io_dmi_hard_reset = 1'b0;
    bus.io_dm_req_ready = 1'b0; bus.io_dm_resp_valid = 1'b0;
    bus.io_dm_resp_err = 1'b0;
  endtask

  // Advance the model by one cycle using the inputs currently applied.
  task automatic model_step();
    bit req, done;
    req = bus.io_wr_en | bus.io_rd_en;
    if (reset) begin
      m_busy = 0; m_granted = 0; m_write = 0; m_age = 0;
      m_stat = 2'd0; m_addr = 7'd0; m_wdata = 32'd0; m_rd = 32'd0;
    end else if (bus.io_dmi_hard_reset) begin
      m_busy = 0; m_granted = 0; m_age = 0; m_stat = 2'd0;
    end else begin
      if (!m_busy) begin
        if (req && (m_stat == 2'd0 || bus.io_dmi_reset)) begin
          m_busy = 1; m_granted = 0; m_age = 0;
          m_write = bus.io_wr_en; m_addr = bus.io_wr_addr; m_wdata = bus.io_wr_data;
        end
      end else begin
        m_age = m_age + 1;
        done = 0;
        if (m_granted && bus.io_dm_resp_valid) begin
          done = 1;
          if (bus.io_dm_resp_err) m_stat = 2'd2;
          else if (!m_write) m_rd = bus.io_dm_resp_data;
        end else if (m_age >= TMO) begin
          done = 1;
          m_stat = 2'd2;
        end else if (!m_granted && bus.io_dm_req_ready) begin
          m_granted = 1;
        end
        if (done) begin m_busy = 0; m_granted = 0; end
        if (req && m_stat == 2'd0) m_stat = 2'd3;
      end
      if (bus.io_dmi_reset) m_stat = 2'd0;
    end
  endtask

  // One clock: update model, clock edge, sample and compare all outputs.
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check_eq("valid", {31'd0, bus.io_dm_req_valid}, {31'd0, (m_busy && !m_granted)});
    check_eq("busy",  {31'd0, bus.io_busy},         {31'd0, m_busy});
    check_eq("write", {31'd0, bus.io_dm_req_write}, {31'd0, m_write});
    check_eq("addr",  {25'd0, bus.io_dm_req_addr},  {25'd0, m_addr});
    check_eq("wdata", bus.io_dm_req_wdata, m_wdata);
    check_eq("rd_data", bus.io_rd_data, m_rd);
    check_eq("stat",  {30'd0, bus.io_dmi_stat},     {30'd0, m_stat});
  endtask

  initial begin
    idle_inputs();
    bus.io_wr_addr = 7'd0; bus.io_wr_data = 32'd0; bus.io_dm_resp_data = 32'd0;

    // Reset
    reset = 1'b1;
    cycle(); cycle();
    check_eq("rst_stat", {30'd0, bus.io_dmi_stat}, 32'd0);
    check_eq("rst_rd", bus.io_rd_data, 32'd0);
    reset = 1'b0;
    cycle();

    // Read round trip
    bus.io_rd_en = 1'b1; bus.io_wr_addr = 7'h11;
    cycle();
    idle_inputs();
    check_eq("rt_valid", {31'd0, bus.io_dm_req_valid}, 32'd1);
    bus.io_dm_req_ready = 1'b1;
    cycle();
    idle_inputs();
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    check_eq("rt_write", {31'd0, bus.io_dm_req_write}, 32'd0);
    check_eq("rt_addr", {25'd0, bus.io_dm_req_addr}, 32'h11);
    check_eq("rt_rd", bus.io_rd_data, 32'hDEADBEEF);
    check_eq("rt_stat", {30'd0, bus.io_dmi_stat}, 32'd0);
    check_eq("rt_busy", {31'd0, bus.io_busy}, 32'd0);

    // Write with backpressure
    bus.io_wr_en = 1'b1; bus.io_wr_addr = 7'h10; bus.io_wr_data = 32'h1;
    cycle();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_valid", {31'd0, bus.io_dm_req_valid}, 32'd1);
      check_eq("bp_addr", {25'd0, bus.io_dm_req_addr}, 32'h10);
      check_eq("bp_wdata", bus.io_dm_req_wdata, 32'h1);
      bus.io_dm_req_ready = (i == 5);
      cycle();
    end
    idle_inputs();
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_data = 32'h12345678;
    cycle();
    idle_inputs();
    check_eq("bp_stat", {30'd0, bus.io_dmi_stat}, 32'd0);
    check_eq("bp_rd", bus.io_rd_data, 32'hDEADBEEF);

    // Busy error, drop while sticky, clear, accept
    bus.io_rd_en = 1'b1; bus.io_wr_addr = 7'h22;
    cycle(); idle_inputs();
    bus.io_dm_req_ready = 1'b1;
    cycle(); idle_inputs();
    bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_data = 32'hCAFE0001;
    cycle(); idle_inputs();
    check_eq("be_stat", {30'd0, bus.io_dmi_stat}, 32'd3);
    bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    check_eq("be_drop", {31'd0, bus.io_busy}, 32'd0);
    bus.io_dmi_reset = 1'b1;
    cycle(); idle_inputs();
    check_eq("be_clr", {30'd0, bus.io_dmi_stat}, 32'd0);
    bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    check_eq("be_accept", {31'd0, bus.io_busy}, 32'd1);
    bus.io_dm_req_ready = 1'b1;
    cycle(); idle_inputs();
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_data = 32'h00000055;
    cycle(); idle_inputs();

    // Error response
    bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    bus.io_dm_req_ready = 1'b1;
    cycle(); idle_inputs();
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_err = 1'b1; bus.io_dm_resp_data = 32'hBAD0BAD0;
    cycle(); idle_inputs();
    check_eq("err_stat", {30'd0, bus.io_dmi_stat}, 32'd2);
    check_eq("err_rd", bus.io_rd_data, 32'h00000055);
    bus.io_dmi_reset = 1'b1;
    cycle(); idle_inputs();

    // Timeout: accept at N, IDLE and stat=2 at N+9
    bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    bus.io_dm_req_ready = 1'b1;
    cycle(); idle_inputs();
    for (int i = 2; i < TMO; i++) cycle();
    check_eq("to_busy_n8", {31'd0, bus.io_busy}, 32'd1);
    cycle();
    check_eq("to_busy_n9", {31'd0, bus.io_busy}, 32'd0);
    check_eq("to_stat", {30'd0, bus.io_dmi_stat}, 32'd2);
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_data = 32'h77777777;
    cycle(); idle_inputs();
    check_eq("to_late_rd", bus.io_rd_data, 32'h00000055);
    bus.io_dmi_reset = 1'b1;
    cycle(); idle_inputs();

    // Hard reset while in REQ
    bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    bus.io_dmi_hard_reset = 1'b1; bus.io_rd_en = 1'b1;
    cycle(); idle_inputs();
    check_eq("hr_valid", {31'd0, bus.io_dm_req_valid}, 32'd0);
    check_eq("hr_busy", {31'd0, bus.io_busy}, 32'd0);
    check_eq("hr_stat", {30'd0, bus.io_dmi_stat}, 32'd0);
    check_eq("hr_rd", bus.io_rd_data, 32'h00000055);

    // Simultaneous wr_en and rd_en
    bus.io_wr_en = 1'b1; bus.io_rd_en = 1'b1; bus.io_wr_addr = 7'h05; bus.io_wr_data = 32'hA5A5A5A5;
    cycle(); idle_inputs();
    check_eq("both_write", {31'd0, bus.io_dm_req_write}, 32'd1);
    bus.io_dm_req_ready = 1'b1;
    cycle(); idle_inputs();
    bus.io_dm_resp_valid = 1'b1; bus.io_dm_resp_data = 32'h99999999;
    cycle(); idle_inputs();
    check_eq("both_rd", bus.io_rd_data, 32'h00000055);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bus.io_wr_en          = ($urandom_range(0, 7) == 0);
      bus.io_rd_en          = ($urandom_range(0, 5) == 0);
      bus.io_wr_addr        = 7'($urandom);
      bus.io_wr_data        = $urandom;
      bus.io_dmi_reset      = ($urandom_range(0, 19) == 0);
      bus.io_dmi_hard_reset = ($urandom_range(0, 59) == 0);
      bus.io_dm_req_ready   = ($urandom_range(0, 2) == 0);
      bus.io_dm_resp_valid  = ($urandom_range(0, 2) == 0);
      bus.io_dm_resp_data   = $urandom;
      bus.io_dm_resp_err    = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
